// File: rtl/ps2_keys_pkg.sv
// Shared types and byte constants for the PS/2 game-key decoder.
package ps2_keys_pkg;

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_ACK = 8'hFA;
   localparam logic [7:0] PS2_BAT = 8'hAA;

   // Bytes the keyboard emits for housekeeping; they never affect key state.
   function automatic logic is_filler(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_BAT) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat down-counter: loads DELAY on start, ticks at 1 and reloads PERIOD.
module key_repeat_timer #(
   parameter int CNT_W  = 26,
   parameter int DELAY  = 25_000_000,
   parameter int PERIOD = 5_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic stop,
   output logic tick
);

   localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // Zero means idle; a zero DELAY therefore disables repeating entirely.
   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (start)
         count <= DELAY_C;
      else if (stop)
         count <= '0;
      else if (count == ONE)
         count <= PERIOD_C;
      else if (count != '0)
         count <= count - ONE;
   end

   assign tick = (count == ONE);

endmodule

// File: rtl/ps2_game_keys.sv
// PS/2 scancode decoder producing held levels and press/auto-repeat pulses per key.
module ps2_game_keys
   import ps2_keys_pkg::*;
#(
   parameter int                    NUM_KEYS      = 6,
   parameter logic [8*NUM_KEYS-1:0] KEY_CODES     = 48'h443A_2324_2B1B,
   parameter logic [NUM_KEYS-1:0]   KEY_EXT       = '0,
   parameter int                    CNT_W         = 26,
   parameter int                    REPEAT_DELAY  = 25_000_000,
   parameter int                    REPEAT_PERIOD = 5_000_000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          ps2_key_data,
   input  logic                ps2_key_pressed,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic [7:0]          last_code,
   output logic                proto_err
);

   ps2_state_t          state;
   logic [NUM_KEYS-1:0] owner;
   logic [NUM_KEYS-1:0] match;
   logic [NUM_KEYS-1:0] make_hit;
   logic [NUM_KEYS-1:0] brk_hit;
   logic [NUM_KEYS-1:0] new_press;
   logic [NUM_KEYS-1:0] next_held;
   logic is_ext_byte, is_brk_byte, is_code, in_ext, in_brk, err;
   logic any_new, owner_stop, tick, repeat_fire;

   assign is_ext_byte = (ps2_key_data == PS2_EXT);
   assign is_brk_byte = (ps2_key_data == PS2_BRK);
   assign is_code     = !is_ext_byte && !is_brk_byte && !is_filler(ps2_key_data);
   assign in_ext      = (state == EXT) || (state == EXT_BRK);
   assign in_brk      = (state == BRK) || (state == EXT_BRK);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_match
      assign match[i] = (KEY_CODES[8*i +: 8] == ps2_key_data) && (KEY_EXT[i] == in_ext);
   end

   assign make_hit  = (ps2_key_pressed && is_code && !in_brk) ? match : '0;
   assign brk_hit   = (ps2_key_pressed && is_code &&  in_brk) ? match : '0;
   assign new_press = make_hit & ~key_held;
   assign next_held = (key_held | new_press) & ~brk_hit;
   assign any_new   = |new_press;

   // A fresh press pre-empts both the old owner's expiry and any release handling.
   assign owner_stop  = !any_new && |(owner & brk_hit);
   assign repeat_fire = tick && !any_new && !owner_stop;

   assign err = ps2_key_pressed &&
                ((in_brk && (is_ext_byte || is_brk_byte)) || (state == EXT && is_ext_byte));

   key_repeat_timer #(
      .CNT_W  (CNT_W),
      .DELAY  (REPEAT_DELAY),
      .PERIOD (REPEAT_PERIOD)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .start (any_new),
      .stop  (owner_stop),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         key_held  <= '0;
         key_n     <= '1;
         key_pulse <= '0;
         last_code <= '0;
         proto_err <= 1'b0;
         owner     <= '0;
      end else begin
         key_held  <= next_held;
         key_n     <= ~next_held;
         proto_err <= err;

         if (any_new)
            key_pulse <= new_press;
         else if (repeat_fire)
            key_pulse <= owner;
         else
            key_pulse <= '0;

         // Lowest-index newly pressed channel takes ownership (x & -x isolates it).
         if (any_new)
            owner <= new_press & (-new_press);
         else if (owner_stop)
            owner <= '0;

         if (ps2_key_pressed && is_code)
            last_code <= ps2_key_data;

         if (ps2_key_pressed) begin
            if (err || is_code)
               state <= IDLE;
            else if (is_ext_byte)
               state <= EXT;
            else if (is_brk_byte)
               state <= (state == EXT) ? EXT_BRK : BRK;
         end
      end
   end

endmodule

// File: tb/tb_ps2_game_keys.sv
// Self-checking bench: directed scenarios plus randomized bytes against a behavioural model.
module tb_ps2_game_keys;

   localparam int NK = 6;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    ps2_key_data = 8'h00;
   logic          ps2_key_pressed = 1'b0;
   logic [NK-1:0] held_a, n_a, pulse_a, held_b, n_b, pulse_b;
   logic [7:0]    last_a, last_b;
   logic          perr_a, perr_b;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint cyc = 0;

   // Model state, index 0 mirrors dut_a, index 1 mirrors dut_b.
   logic [7:0]    m_code[2][NK];
   bit            m_ext[2][NK];
   int            m_delay[2];
   int            m_period[2];
   bit [NK-1:0]   m_held[2];
   bit [NK-1:0]   m_pulse[2];
   int            m_owner[2];
   longint        m_next[2];
   bit            m_pe0[2], m_pf0[2], m_perr[2];
   logic [7:0]    m_last[2];

   always #5 clock = ~clock;

   ps2_game_keys #(
      .NUM_KEYS(6), .KEY_CODES(48'h443A_2375_2B1B), .KEY_EXT(6'b000100),
      .CNT_W(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
   ) dut_a (
      .clock(clock), .reset(reset), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .key_held(held_a), .key_n(n_a),
      .key_pulse(pulse_a), .last_code(last_a), .proto_err(perr_a)
   );

   ps2_game_keys #(
      .REPEAT_DELAY(0)
   ) dut_b (
      .clock(clock), .reset(reset), .ps2_key_data(ps2_key_data),
      .ps2_key_pressed(ps2_key_pressed), .key_held(held_b), .key_n(n_b),
      .key_pulse(pulse_b), .last_code(last_b), .proto_err(perr_b)
   );

   // Computes what the outputs must be after the edge that ends cycle 'cyc'.
   task automatic model_step(input int m);
      bit         rep_due, ext, brk;
      int         first;
      logic [7:0] b;
      rep_due  = (m_owner[m] >= 0) && (m_delay[m] > 0) && (m_next[m] == cyc + 1);
      m_pulse[m] = '0;
      m_perr[m]  = 1'b0;
      if (reset) begin
         m_held[m] = '0; m_owner[m] = -1; m_pe0[m] = 0; m_pf0[m] = 0; m_last[m] = 8'h00;
         return;
      end
      if (ps2_key_pressed) begin
         b = ps2_key_data;
         if (b inside {8'hFA, 8'hAA, 8'h00, 8'hFF}) begin
         end else if (b == 8'hE0) begin
            if (m_pe0[m] || m_pf0[m]) begin m_perr[m] = 1; m_pe0[m] = 0; m_pf0[m] = 0; end
            else m_pe0[m] = 1;
         end else if (b == 8'hF0) begin
            if (m_pf0[m]) begin m_perr[m] = 1; m_pe0[m] = 0; m_pf0[m] = 0; end
            else m_pf0[m] = 1;
         end else begin
            ext = m_pe0[m]; brk = m_pf0[m];
            m_pe0[m] = 0; m_pf0[m] = 0; m_last[m] = b; first = -1;
            for (int i = 0; i < NK; i++) begin
               if (m_code[m][i] == b && m_ext[m][i] == ext) begin
                  if (brk) begin
                     m_held[m][i] = 0;
                     if (m_owner[m] == i) begin m_owner[m] = -1; rep_due = 0; end
                  end else if (!m_held[m][i]) begin
                     m_held[m][i] = 1; m_pulse[m][i] = 1;
                     if (first < 0) first = i;
                  end
               end
            end
            if (first >= 0) begin
               m_owner[m] = first; m_next[m] = cyc + 1 + m_delay[m]; rep_due = 0;
            end
         end
      end
      if (rep_due) begin
         m_pulse[m][m_owner[m]] = 1;
         m_next[m] += m_period[m];
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step(0);
      model_step(1);
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic drive(input logic [7:0] b);
      ps2_key_data = b;
      ps2_key_pressed = 1'b1;
      cycle();
      ps2_key_pressed = 1'b0;
   endtask

   function automatic bit rep_expected(input int k);
      return (k == 1) || (k >= 11 && (k - 11) % 4 == 0);
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      n_cmp++;
      if ({held_a, n_a, pulse_a, last_a, perr_a} !== {6'h00, 6'h3F, 6'h00, 8'h00, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL reset_a: got held=%h n=%h pulse=%h last=%h err=%b, expected 00 3f 00 00 0",
                  held_a, n_a, pulse_a, last_a, perr_a);
      end
      n_cmp++;
      if ({held_b, n_b, pulse_b, last_b, perr_b} !== {6'h00, 6'h3F, 6'h00, 8'h00, 1'b0}) begin
         n_bad++;
         $display("[TB] FAIL reset_b: got held=%h n=%h pulse=%h last=%h err=%b, expected 00 3f 00 00 0",
                  held_b, n_b, pulse_b, last_b, perr_b);
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_make_break();
      drive(8'h1B);
      n_cmp++;
      if ({pulse_b[0], held_b[0], n_b[0]} !== 3'b110) begin
         n_bad++;
         $display("[TB] FAIL make_1b: got pulse/held/n=%b%b%b expected 110", pulse_b[0], held_b[0], n_b[0]);
      end
      for (int k = 0; k < 4; k++) begin
         idle(1);
         n_cmp++;
         if ({pulse_b[0], held_b[0]} !== 2'b01) begin
            n_bad++;
            $display("[TB] FAIL hold_1b_%0d: got pulse/held=%b%b expected 01", k, pulse_b[0], held_b[0]);
         end
      end
      drive(8'hF0);
      n_cmp++;
      if (held_b[0] !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL held_after_f0: got %b expected 1", held_b[0]);
      end
      drive(8'h1B);
      n_cmp++;
      if ({pulse_b[0], held_b[0], n_b[0], last_b} !== {3'b001, 8'h1B}) begin
         n_bad++;
         $display("[TB] FAIL break_1b: got pulse/held/n=%b%b%b last=%h expected 001 1b",
                  pulse_b[0], held_b[0], n_b[0], last_b);
      end
      idle(2);
   endtask

   task automatic test_auto_repeat();
      drive(8'h2B);
      for (int k = 1; k <= 31; k++) begin
         n_cmp++;
         if (pulse_a[1] !== rep_expected(k)) begin
            n_bad++;
            $display("[TB] FAIL repeat_cycle_%0d: got %b expected %b", k, pulse_a[1], rep_expected(k));
         end
         if (k < 31) idle(1);
      end
      drive(8'hF0);
      drive(8'h2B);
      n_cmp++;
      if (held_a[1] !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL repeat_release: got held=%b expected 0", held_a[1]);
      end
      for (int k = 0; k < 20; k++) begin
         idle(1);
         n_cmp++;
         if (pulse_a[1] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL after_release_%0d: got pulse=%b expected 0", k, pulse_a[1]);
         end
      end
   endtask

   task automatic test_typematic();
      drive(8'h23);
      for (int k = 1; k <= 20; k++) begin
         n_cmp++;
         if (pulse_a[3] !== rep_expected(k)) begin
            n_bad++;
            $display("[TB] FAIL typematic_cycle_%0d: got %b expected %b", k, pulse_a[3], rep_expected(k));
         end
         if (k == 3 || k == 5 || k == 7) drive(8'h23);
         else idle(1);
      end
      drive(8'hF0);
      drive(8'h23);
      n_cmp++;
      if ({held_a[3], pulse_a[3]} !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL release_at_expiry: got held/pulse=%b%b expected 00", held_a[3], pulse_a[3]);
      end
      idle(3);
   endtask

   task automatic test_extended();
      drive(8'h75);
      n_cmp++;
      if ({held_a[2], pulse_a[2], last_a} !== {2'b00, 8'h75}) begin
         n_bad++;
         $display("[TB] FAIL plain_75: got held/pulse=%b%b last=%h expected 00 75", held_a[2], pulse_a[2], last_a);
      end
      drive(8'hE0);
      drive(8'h75);
      n_cmp++;
      if ({held_a[2], pulse_a[2]} !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL ext_make_75: got held/pulse=%b%b expected 11", held_a[2], pulse_a[2]);
      end
      drive(8'hE0);
      drive(8'hF0);
      drive(8'h75);
      n_cmp++;
      if (held_a[2] !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL ext_break_75: got held=%b expected 0", held_a[2]);
      end
      idle(2);
   endtask

   task automatic test_proto_err();
      drive(8'hF0);
      drive(8'hE0);
      n_cmp++;
      if ({perr_a, perr_b} !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL err_f0_e0: got %b%b expected 11", perr_a, perr_b);
      end
      idle(1);
      n_cmp++;
      if (perr_a !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL err_one_cycle: got %b expected 0", perr_a);
      end
      drive(8'h23);
      drive(8'hFA);
      n_cmp++;
      if ({held_a[3], last_a} !== {1'b1, 8'h23}) begin
         n_bad++;
         $display("[TB] FAIL after_err_make: got held=%b last=%h expected 1 23", held_a[3], last_a);
      end
      drive(8'hE0);
      drive(8'hE0);
      n_cmp++;
      if (perr_a !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL err_e0_e0: got %b expected 1", perr_a);
      end
      drive(8'hF0);
      drive(8'h23);
      n_cmp++;
      if (held_a[3] !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL after_err_break: got held=%b expected 0", held_a[3]);
      end
      idle(2);
   endtask

   task automatic test_back_to_back();
      drive(8'h1B);
      n_cmp++;
      if (pulse_a !== 6'b000001) begin
         n_bad++;
         $display("[TB] FAIL b2b_first: got pulse=%b expected 000001", pulse_a);
      end
      drive(8'h2B);
      n_cmp++;
      if ({pulse_a, held_a} !== {6'b000010, 6'b000011}) begin
         n_bad++;
         $display("[TB] FAIL b2b_second: got pulse=%b held=%b expected 000010 000011", pulse_a, held_a);
      end
      drive(8'hE0);
      drive(8'h75);
      n_cmp++;
      if (held_a !== 6'b000111) begin
         n_bad++;
         $display("[TB] FAIL b2b_third: got held=%b expected 000111", held_a);
      end
      drive(8'hF0); drive(8'h1B);
      drive(8'hF0); drive(8'h2B);
      drive(8'hE0); drive(8'hF0); drive(8'h75);
      n_cmp++;
      if (held_a !== 6'b000000) begin
         n_bad++;
         $display("[TB] FAIL b2b_release: got held=%b expected 000000", held_a);
      end
      idle(2);
   endtask

   task automatic test_reset_mid_repeat();
      drive(8'h1B);
      idle(11);
      reset = 1'b1;
      ps2_key_data = 8'h2B;
      ps2_key_pressed = 1'b1;
      cycle();
      reset = 1'b0;
      ps2_key_pressed = 1'b0;
      n_cmp++;
      if ({held_a, n_a, pulse_a, last_a, perr_a, held_b, pulse_b} !==
          {6'h00, 6'h3F, 6'h00, 8'h00, 1'b0, 6'h00, 6'h00}) begin
         n_bad++;
         $display("[TB] FAIL mid_reset: got held=%h n=%h pulse=%h last=%h err=%b held_b=%h, expected 00 3f 00 00 0 00",
                  held_a, n_a, pulse_a, last_a, perr_a, held_b);
      end
      for (int k = 0; k < 25; k++) begin
         idle(1);
         n_cmp++;
         if ({pulse_a, pulse_b, held_a} !== 18'h0) begin
            n_bad++;
            $display("[TB] FAIL quiet_after_reset_%0d: got pulse=%h held=%h expected 0 0", k, pulse_a, held_a);
         end
      end
      drive(8'h1B);
      n_cmp++;
      if ({pulse_a[0], held_a[0]} !== 2'b11) begin
         n_bad++;
         $display("[TB] FAIL fresh_make: got pulse/held=%b%b expected 11", pulse_a[0], held_a[0]);
      end
      drive(8'hF0);
      drive(8'h1B);
      idle(2);
   endtask

   task automatic test_random();
      logic [7:0]  pool[18] = '{8'h1B, 8'h2B, 8'h23, 8'h24, 8'h3A, 8'h44, 8'h75, 8'hE0, 8'hE0,
                                8'hF0, 8'hF0, 8'hF0, 8'hFA, 8'hAA, 8'h00, 8'hFF, 8'h12, 8'h1C};
      logic [26:0] got, exp;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 99) < 45) drive(pool[$urandom_range(0, 17)]);
         else idle(1);
         got = {held_a, n_a, pulse_a, last_a, perr_a};
         exp = {m_held[0], ~m_held[0], m_pulse[0], m_last[0], m_perr[0]};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL random_a_%0d: got %h expected %h", k, got, exp);
         end
         got = {held_b, n_b, pulse_b, last_b, perr_b};
         exp = {m_held[1], ~m_held[1], m_pulse[1], m_last[1], m_perr[1]};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL random_b_%0d: got %h expected %h", k, got, exp);
         end
      end
   endtask

   initial begin
      logic [47:0] codes_a, codes_b;
      codes_a = 48'h443A_2375_2B1B;
      codes_b = 48'h443A_2324_2B1B;
      for (int i = 0; i < NK; i++) begin
         m_code[0][i] = codes_a[8*i +: 8];
         m_code[1][i] = codes_b[8*i +: 8];
         m_ext[0][i]  = (i == 2);
         m_ext[1][i]  = 1'b0;
      end
      m_delay  = '{10, 0};
      m_period = '{4, 5_000_000};
      m_owner  = '{-1, -1};
      m_next   = '{0, 0};
      m_held   = '{6'h0, 6'h0};
      m_last   = '{8'h0, 8'h0};

      test_reset();
      test_make_break();
      test_auto_repeat();
      test_typematic();
      test_extended();
      test_proto_err();
      test_back_to_back();
      test_reset_mid_repeat();
      test_random();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
